// File: rtl/mem_bus_master.sv
// Bus-master sequencer behind MEM: arbitrates, strobes, waits for rdy,
// returns read data with a done pulse, aborts with err on timeout.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_req_i           MEM access request (level, held while stalled)
//   mem_rw_i            1 = read, 0 = write
//   mem_addr_i          access address
//   mem_wr_data_i       write data
//   mem_rd_data_o       read data, valid with done and !err
//   mem_done_o          one-cycle completion pulse
//   mem_err_o           one-cycle timeout pulse, coincident with done
//   mem_stall_o         combinational stall to the pipeline
//   bus_req_o           request to the arbiter
//   bus_grnt_i          grant from the arbiter
//   bus_as_o            address strobe, one cycle per access
//   bus_rw_o            1 = read, 0 = write
//   bus_addr_o          bus address
//   bus_wr_data_o       bus write data
//   bus_rd_data_i       slave read data, sampled when rdy
//   bus_rdy_i           slave ready
module mem_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_rw_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wr_data_i,
  output logic [DATA_W-1:0] mem_rd_data_o,
  output logic              mem_done_o,
  output logic              mem_err_o,
  output logic              mem_stall_o,
  output logic              bus_req_o,
  input  logic              bus_grnt_i,
  output logic              bus_as_o,
  output logic              bus_rw_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wr_data_o,
  input  logic [DATA_W-1:0] bus_rd_data_i,
  input  logic              bus_rdy_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    WAIT
  } state_e;

  localparam int unsigned LAST =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST =
    LAST[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  logic to_hit;

  // A retiring request is still high in the done
  // cycle; done_q keeps it from being taken twice.
  assign accept = (state_q == IDLE) & mem_req_i
                & ~done_q;

  assign to_hit = (TIMEOUT != 0)
                & (cnt_q >= CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bus_req_o = 1'b0;
    bus_as_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = mem_addr_i;
          rw_d    = mem_rw_i;
          wdata_d = mem_wr_data_i;
          // The accept cycle is the first cycle
          // of the timeout window.
          cnt_d   = CNT_ONE;
          state_d = REQ;
        end
      end
      REQ: begin
        bus_req_o = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        if (to_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (bus_grnt_i) begin
          state_d = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        bus_req_o = 1'b1;
        bus_as_o  = (state_q == ACCESS);
        cnt_d     = cnt_q + CNT_ONE;
        // rdy beats a coincident timeout.
        if (bus_rdy_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (rw_q) begin
            rdata_d = bus_rd_data_i;
          end
        end else if (to_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_stall_o   = (state_q != IDLE) | accept;
  assign mem_rd_data_o = rdata_q;
  assign mem_done_o    = done_q;
  assign mem_err_o     = err_q;
  assign bus_rw_o      = rw_q;
  assign bus_addr_o    = addr_q;
  assign bus_wr_data_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: directed cases plus random
// accesses against a cycle-offset reference model.
module tb_mem_bus_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i;
  logic        mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wr_data_i;
  logic [31:0] mem_rd_data_o;
  logic        mem_done_o;
  logic        mem_err_o;
  logic        mem_stall_o;
  logic        bus_req_o;
  logic        bus_grnt_i;
  logic        bus_as_o;
  logic        bus_rw_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wr_data_o;
  logic [31:0] bus_rd_data_i;
  logic        bus_rdy_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_rd;

  mem_bus_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_i    (mem_req_i),
    .mem_rw_i     (mem_rw_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wr_data_i(mem_wr_data_i),
    .mem_rd_data_o(mem_rd_data_o),
    .mem_done_o   (mem_done_o),
    .mem_err_o    (mem_err_o),
    .mem_stall_o  (mem_stall_o),
    .bus_req_o    (bus_req_o),
    .bus_grnt_i   (bus_grnt_i),
    .bus_as_o     (bus_as_o),
    .bus_rw_o     (bus_rw_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wr_data_o(bus_wr_data_o),
    .bus_rd_data_i(bus_rd_data_i),
    .bus_rdy_i    (bus_rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One access. g = cycles grant lags the REQ cycle,
  // r = cycles rdy lags the strobe. Offsets are in
  // cycles from the accept cycle (offset 0).
  task automatic run_txn(input bit          rw,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int          g,
                         input int          r);
    int  k;
    int  exp_done;
    int  as_exp;
    int  as_cnt;
    bit  exp_err;
    bit  fin;
    k        = g + 2 + r;
    exp_err  = (k > TO - 1);
    exp_done = exp_err ? TO : k + 1;
    as_exp   = (g + 2 <= TO - 1) ? 1 : 0;
    as_cnt   = 0;
    fin      = 1'b0;
    mem_req_i     = 1'b1;
    mem_rw_i      = rw;
    mem_addr_i    = a;
    mem_wr_data_i = wd;
    for (int off = 0; off <= TO + 4 && !fin; off++) begin
      bus_grnt_i    = (off >= g + 1);
      bus_rdy_i     = (off == k);
      bus_rd_data_i = (off == k) ? rd : $urandom;
      #1;
      if (mem_done_o) begin
        fin = 1'b1;
        if (rw && !exp_err) exp_rd = rd;
        chk("done_off", off, exp_done);
        chk("err", mem_err_o, exp_err);
        chk("rd_data", mem_rd_data_o, exp_rd);
        chk("stall_done", mem_stall_o, 0);
        chk("req_done", bus_req_o, 0);
        chk("addr_hold", bus_addr_o, a);
        chk("rw_hold", bus_rw_o, rw);
      end else begin
        chk("stall_busy", mem_stall_o, 1);
        if (bus_as_o) begin
          as_cnt++;
          chk("as_addr", bus_addr_o, a);
          chk("as_rw", bus_rw_o, rw);
          if (!rw) chk("as_wdata", bus_wr_data_o, wd);
        end
      end
      next_cyc();
    end
    if (!fin) chk("done_seen", 0, 1);
    chk("as_count", as_cnt, as_exp);
    bus_grnt_i = 1'b0;
    bus_rdy_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    mem_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_stall", mem_stall_o, 0);
      chk("idle_done", mem_done_o, 0);
      next_cyc();
    end
  endtask

  initial begin
    rst           = 1'b1;
    mem_req_i     = 1'b0;
    mem_rw_i      = 1'b0;
    mem_addr_i    = '0;
    mem_wr_data_i = '0;
    bus_grnt_i    = 1'b0;
    bus_rdy_i     = 1'b0;
    bus_rd_data_i = '0;
    exp_rd        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus_req_o, 0);
    chk("rst_as", bus_as_o, 0);
    chk("rst_done", mem_done_o, 0);
    chk("rst_err", mem_err_o, 0);
    chk("rst_stall", mem_stall_o, 0);
    chk("rst_rw", bus_rw_o, 1);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rd", mem_rd_data_o, 0);
    rst = 1'b0;
    next_cyc();

    // minimum-latency write
    run_txn(1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 0, 0);
    idle(1);
    // delayed grant and rdy; rdy lands on the
    // last cycle of the timeout window
    run_txn(1'b1, 32'h44, 32'h0, 32'h12345678, 3, 2);
    // rdy never comes
    run_txn(1'b1, 32'h48, 32'h0, 32'hCAFEF00D, 0, 100);
    // rdy exactly on the timeout cycle
    run_txn(1'b1, 32'h4C, 32'h0, 32'hA5A5_5A5A, 0, 5);
    // grant never comes in time
    run_txn(1'b0, 32'h50, 32'h1, 32'h0, 9, 0);
    idle(1);

    // reset while waiting for rdy
    mem_req_i  = 1'b1;
    mem_rw_i   = 1'b1;
    mem_addr_i = 32'h60;
    for (int off = 0; off < 4; off++) begin
      bus_grnt_i = (off >= 1);
      next_cyc();
    end
    rst        = 1'b1;
    mem_req_i  = 1'b0;
    bus_grnt_i = 1'b0;
    next_cyc();
    rst = 1'b0;
    #1;
    chk("wrst_req", bus_req_o, 0);
    chk("wrst_as", bus_as_o, 0);
    chk("wrst_done", mem_done_o, 0);
    chk("wrst_err", mem_err_o, 0);
    chk("wrst_stall", mem_stall_o, 0);
    chk("wrst_rw", bus_rw_o, 1);
    exp_rd = '0;
    next_cyc();
    idle(2);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 6)),
              int'($urandom_range(0, 6)));
      if ($urandom_range(0, 2) != 0)
        idle(int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
